// File: rtl/regfile_dump_reader_if.sv
// Bundles the control, register-file read port and output stream of the dump reader.
// The slave modport is the reader itself; the master modport is whoever drives it.
interface regfile_dump_reader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              start;
    logic [ADDR_W-1:0] first_reg;
    logic [ADDR_W-1:0] last_reg;
    logic [ADDR_W-1:0] rd_reg;
    logic [DATA_W-1:0] rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_index;
    logic              out_last;
    logic              busy;
    logic              done;

    modport master (
        output start, first_reg, last_reg, rd_data, out_ready,
        input  rd_reg, out_valid, out_data, out_index, out_last, busy, done
    );

    modport slave (
        input  start, first_reg, last_reg, rd_data, out_ready,
        output rd_reg, out_valid, out_data, out_index, out_last, busy, done
    );
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks a (possibly wrapping) range of register-file indices, snapshots each word
// on its own READ cycle and streams it out over a valid/ready handshake.
module regfile_dump_reader #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_dump_reader_if.slave  bus
);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] end_idx_q, end_idx_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_index_q, out_index_d;
    logic              out_last_q, out_last_d;
    logic              out_valid_q, out_valid_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            end_idx_q   <= '0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            end_idx_q   <= end_idx_d;
            out_data_q  <= out_data_d;
            out_index_q <= out_index_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        end_idx_d   = end_idx_q;
        out_data_d  = out_data_q;
        out_index_d = out_index_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    idx_d     = bus.first_reg;
                    end_idx_d = bus.last_reg;
                    state_d   = READ;
                end
            end
            READ: begin
                out_data_d  = bus.rd_data;
                out_index_d = idx_q;
                out_last_d  = (idx_q == end_idx_q);
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                // Output fields stay frozen until the consumer takes the word.
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (out_last_q) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + ADDR_W'(1);
                        state_d = READ;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.rd_reg    = (state_q == IDLE) ? '0 : idx_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_index = out_index_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
endmodule

// File: tb/tb_regfile_dump_reader.sv
// Randomized bench for regfile_dump_reader: a behavioural register file feeds the
// reader, and a range-arithmetic reference model predicts every streamed word.
module tb_regfile_dump_reader;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    regfile_dump_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    regfile_dump_reader #(.NUM_REGS(NREGS), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DW-1:0] regs    [NREGS];
    logic [DW-1:0] expRegs [NREGS];

    // Register file read port: index 0 is hardwired to zero.
    assign bus.rd_data = (bus.rd_reg == '0) ? '0 : regs[bus.rd_reg];

    int checks = 0;
    int passes = 0;

    task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                               input logic [DW-1:0] expected);
        checks++;
        if (observed === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
    endtask

    function automatic logic [DW-1:0] expData(input logic [AW-1:0] i);
        return (i == '0) ? '0 : expRegs[i];
    endfunction

    task automatic applyStimulus(input logic [AW-1:0] f, input logic [AW-1:0] l);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.first_reg = f;
        bus.last_reg  = l;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        checkOutput({tag, "_busy"},  32'(bus.busy),      32'd0);
        checkOutput({tag, "_done"},  32'(bus.done),      32'd0);
        checkOutput({tag, "_rdReg"}, 32'(bus.rd_reg),    32'd0);
    endtask

    // Runs one dump and checks every cycle against the range model.
    task automatic runDump(input logic [AW-1:0] f, input logic [AW-1:0] l,
                           input int readyPct, input int holdCycles,
                           input int glitchAt, input int writeAt);
        int expCount;
        int got;
        int cyc;
        int validSeen;
        int acceptCyc;
        bit doneSeen;
        bit glitched;
        bit wrote;
        bit newWord;
        bit ready;
        logic [AW-1:0] expIdx;
        expCount  = ((int'(l) - int'(f) + NREGS) % NREGS) + 1;
        got       = 0;
        cyc       = 0;
        validSeen = 0;
        acceptCyc = 0;
        doneSeen  = 1'b0;
        glitched  = 1'b0;
        wrote     = 1'b0;
        newWord   = 1'b1;
        applyStimulus(f, l);
        while (!doneSeen && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            bus.start = 1'b0;
            if (cyc == 1) begin
                checkOutput("busyAtT1",  32'(bus.busy),      32'd1);
                checkOutput("validAtT1", 32'(bus.out_valid), 32'd0);
            end
            if (bus.done) begin
                doneSeen = 1'b1;
                checkOutput("wordCount",  32'(got), 32'(expCount));
                checkOutput("doneTiming", 32'(cyc), 32'(acceptCyc + 1));
                checkOutput("doneBusy",   32'(bus.busy), 32'd1);
                if (readyPct == 100 && holdCycles == 0)
                    checkOutput("doneCycle", 32'(cyc), 32'(2 * expCount + 1));
            end else if (bus.out_valid) begin
                expIdx = AW'((int'(f) + got) % NREGS);
                if (newWord) checkOutput("validLatency", 32'(cyc - acceptCyc), 32'd2);
                checkOutput("outIndex", 32'(bus.out_index), 32'(expIdx));
                checkOutput("outData",  bus.out_data, expData(expIdx));
                checkOutput("outLast",  32'(bus.out_last), 32'(got == expCount - 1));
                checkOutput("rdReg",    32'(bus.rd_reg), 32'(expIdx));
                validSeen++;
                ready = (validSeen > holdCycles) && ($urandom_range(99) < readyPct);
                bus.out_ready = ready;
                newWord = ready;
                if (ready) begin
                    got++;
                    acceptCyc = cyc;
                end
            end else begin
                bus.out_ready = 1'($urandom_range(1));
            end
            if (!glitched && glitchAt >= 0 && got == glitchAt && cyc > 2) begin
                bus.start     = 1'b1;
                bus.first_reg = f + AW'(7);
                bus.last_reg  = f + AW'(2);
                glitched      = 1'b1;
            end
            if (!wrote && writeAt >= 0 && got == writeAt) begin
                regs[3]  = 32'h1234_5678;
                regs[20] = 32'hCAFE_0000;
                wrote    = 1'b1;
            end
        end
        bus.start = 1'b0;
        if (!doneSeen) checkOutput("doneTimeout", 32'd0, 32'd1);
        @(negedge clk);
        checkIdleOutputs("afterDone");
        repeat (3) begin
            @(negedge clk);
            checkOutput("noSecondDump", 32'(bus.busy), 32'd0);
        end
    endtask

    task automatic loadPattern();
        for (int i = 0; i < NREGS; i++) regs[i] = 32'h1000 + 32'(i);
        regs[0] = '0;
        expRegs = regs;
    endtask

    initial begin
        int cyc;
        logic [AW-1:0] rf;
        logic [AW-1:0] rl;
        bus.start     = 1'b0;
        bus.first_reg = '0;
        bus.last_reg  = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < NREGS; i++) regs[i] = '0;
        expRegs = regs;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkIdleOutputs("reset");
        checkOutput("reset_data",  bus.out_data, 32'd0);
        checkOutput("reset_index", 32'(bus.out_index), 32'd0);
        checkOutput("reset_last",  32'(bus.out_last), 32'd0);
        rst = 1'b0;

        // Full dump with the consumer always ready.
        loadPattern();
        runDump(5'd0, 5'd31, 100, 0, -1, -1);

        // Wrap-around range.
        runDump(5'd30, 5'd1, 100, 0, -1, -1);

        // Single word under ten cycles of back-pressure.
        regs[5] = 32'hDEAD_BEEF;
        expRegs = regs;
        runDump(5'd5, 5'd5, 100, 10, -1, -1);

        // Start pulsed mid-dump must be ignored.
        loadPattern();
        runDump(5'd8, 5'd14, 70, 0, 2, -1);

        // Concurrent writes: R20 before its read, R3 after its capture.
        loadPattern();
        expRegs[20] = 32'hCAFE_0000;
        runDump(5'd0, 5'd31, 100, 0, -1, 10);

        // Reset while holding the third word.
        loadPattern();
        applyStimulus(5'd0, 5'd31);
        cyc = 0;
        while (!(bus.out_valid && bus.out_index == AW'(2)) && cyc < 200) begin
            @(negedge clk);
            cyc++;
            bus.start     = 1'b0;
            bus.out_ready = !(bus.out_valid && bus.out_index == AW'(2));
        end
        checkOutput("reachThirdWord", 32'(bus.out_index), 32'd2);
        bus.out_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkIdleOutputs("midReset");
        checkOutput("midReset_data", bus.out_data, 32'd0);
        checkOutput("midReset_last", 32'(bus.out_last), 32'd0);
        repeat (4) begin
            @(negedge clk);
            checkOutput("noDoneAfterReset", 32'(bus.done), 32'd0);
        end
        runDump(5'd3, 5'd9, 100, 0, -1, -1);

        // Random ranges, contents and back-pressure.
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < NREGS; i++) regs[i] = $urandom;
            expRegs = regs;
            rf = AW'($urandom_range(NREGS - 1));
            rl = AW'($urandom_range(NREGS - 1));
            runDump(rf, rl, 60, 0, -1, -1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
